// File: rtl/fir_pkg.sv
// Shared types, default sizes and the output shift/saturate helper for the FIR datapath.
package fir_pkg;

  localparam int unsigned DefMaxTaps  = 16;
  localparam int unsigned DefFracBits = 16;
  localparam int unsigned AccW        = 64 + $clog2(DefMaxTaps);
  // Wide enough to hold any accumulator this block can be built with.
  localparam int unsigned SatW        = 96;

  typedef enum logic [1:0] {
    StLoad,
    StReady,
    StMac,
    StOut
  } fir_state_e;

  localparam logic signed [SatW-1:0] SatMax = SatW'(signed'(32'h7FFF_FFFF));
  localparam logic signed [SatW-1:0] SatMin = SatW'(signed'(32'h8000_0000));

  function automatic logic [31:0] sat32(input logic signed [SatW-1:0] acc,
                                        input int unsigned frac_bits);
    logic signed [SatW-1:0] sh;
    logic [31:0] res;
    sh = acc >>> frac_bits;
    if (sh > SatMax) begin
      res = 32'h7FFF_FFFF;
    end else if (sh < SatMin) begin
      res = 32'h8000_0000;
    end else begin
      res = sh[31:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed 32x32 multiply-accumulate with clear/enable, plus Q-format rescale and saturation.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int unsigned AW        = AccW,
  parameter int unsigned FRAC_BITS = DefFracBits
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic        [31:0] result
);

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [63:0]   prod;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q + AW'(prod);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end

  assign result = sat32(SatW'(acc_q), FRAC_BITS);

endmodule

// File: rtl/fir_mac_datapath.sv
// FIR datapath: coefficient bank, sample delay line and a one-tap-per-cycle sequential MAC.
module fir_mac_datapath
  import fir_pkg::*;
#(
  parameter int unsigned MAX_TAPS  = DefMaxTaps,
  parameter int unsigned FRAC_BITS = DefFracBits
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tap_count,
  input  logic        coeff_data_valid,
  input  logic [31:0] coeff_data,
  input  logic        x_data_valid,
  input  logic [31:0] x_data,
  input  logic        compute,
  output logic        coefficient_loading_complete,
  output logic        output_data_valid,
  output logic [31:0] output_data,
  output logic        busy,
  output logic        sample_dropped
);

  localparam int unsigned IdxW = $clog2(MAX_TAPS);
  localparam int unsigned CntW = $clog2(MAX_TAPS + 1);
  localparam logic [CntW-1:0] MaxN = CntW'(MAX_TAPS);
  localparam logic [CntW-1:0] One  = CntW'(1);

  fir_state_e state_q, state_d;

  logic signed [31:0] bank_q  [MAX_TAPS];
  logic signed [31:0] delay_q [MAX_TAPS];

  logic [CntW-1:0] wr_ptr_q, idx_q, n_q, n_sel, n_eff;
  logic [IdxW-1:0] wr_addr;
  logic            wr_en, reload, accept, mac_en, out_fire, drop_set, load_done;
  logic [31:0]     mac_result;

  always_comb begin
    if (tap_count == '0) begin
      n_sel = One;
    end else if (tap_count > MAX_TAPS) begin
      n_sel = MaxN;
    end else begin
      n_sel = tap_count[CntW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_eff     = n_q;
    wr_en     = 1'b0;
    reload    = 1'b0;
    accept    = 1'b0;
    mac_en    = 1'b0;
    out_fire  = 1'b0;
    drop_set  = 1'b0;
    load_done = 1'b0;
    unique case (state_q)
      StLoad: begin
        drop_set = x_data_valid;
        if (coeff_data_valid) begin
          wr_en = 1'b1;
          // N is latched by the first write of a load.
          if (wr_ptr_q == '0) n_eff = n_sel;
          if (wr_ptr_q == n_eff - One) begin
            load_done = 1'b1;
            state_d   = StReady;
          end
        end
      end
      StReady: begin
        if (coeff_data_valid) begin
          reload   = 1'b1;
          wr_en    = 1'b1;
          n_eff    = n_sel;
          drop_set = x_data_valid;
          state_d  = (n_sel == One) ? StReady : StLoad;
        end else if (x_data_valid && compute) begin
          accept  = 1'b1;
          state_d = StMac;
        end
      end
      StMac: begin
        mac_en   = 1'b1;
        drop_set = x_data_valid;
        if (idx_q == n_q - One) state_d = StOut;
      end
      StOut: begin
        out_fire = 1'b1;
        drop_set = x_data_valid;
        state_d  = StReady;
      end
      default: state_d = StLoad;
    endcase
  end

  assign wr_addr = reload ? '0 : wr_ptr_q[IdxW-1:0];
  assign busy    = (state_q == StMac);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_TAPS; i++) begin
        bank_q[i]  <= '0;
        delay_q[i] <= '0;
      end
      wr_ptr_q                     <= '0;
      idx_q                        <= '0;
      n_q                          <= One;
      coefficient_loading_complete <= 1'b0;
      sample_dropped               <= 1'b0;
      output_data_valid            <= 1'b0;
      output_data                  <= '0;
    end else begin
      if (wr_en) begin
        bank_q[wr_addr] <= coeff_data;
        n_q             <= n_eff;
      end

      if (reload) begin
        for (int i = 0; i < MAX_TAPS; i++) delay_q[i] <= '0;
      end else if (accept) begin
        delay_q[0] <= x_data;
        for (int i = 1; i < MAX_TAPS; i++) delay_q[i] <= delay_q[i-1];
      end

      if (reload) begin
        wr_ptr_q <= One;
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + One;
      end

      if (accept) begin
        idx_q <= '0;
      end else if (mac_en) begin
        idx_q <= idx_q + One;
      end

      if (reload) begin
        coefficient_loading_complete <= (n_sel == One);
      end else if (load_done) begin
        coefficient_loading_complete <= 1'b1;
      end

      // A reload clears the flag, but a sample colliding with it still counts as dropped.
      if (reload) begin
        sample_dropped <= drop_set;
      end else if (drop_set) begin
        sample_dropped <= 1'b1;
      end

      output_data_valid <= out_fire;
      if (out_fire) output_data <= mac_result;
    end
  end

  fir_mac_unit #(
    .AW        (64 + $clog2(MAX_TAPS)),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .en     (mac_en),
    .a      (delay_q[idx_q[IdxW-1:0]]),
    .b      (bank_q[idx_q[IdxW-1:0]]),
    .result (mac_result)
  );

endmodule
